// File: rtl/traffic_light_pkg.sv
// Shared state encoding, default phase durations and a width helper for the traffic light controller.
// Pure declarations: no latency, no backpressure.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_t;

  localparam int DEF_RED_CYCLES    = 6;
  localparam int DEF_GREEN_CYCLES  = 8;
  localparam int DEF_YELLOW_CYCLES = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that raises done when the count reaches zero; load takes effect on the next edge.
// Free-running, no backpressure; async active-low clear to RST_VAL.
module phase_timer #(
  parameter int CNT_W   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= CNT_W'(RST_VAL);
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/traffic_light_fsm.sv
// Free-running RED->GREEN->YELLOW lamp sequencer with Moore one-hot outputs; phase changes on the edge where the timer is 0.
// No handshake or backpressure. Define TLF_STATE_OUT_EN to expose the registered state on state_o.
module traffic_light_fsm
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  output logic       red,
  output logic       green,
  output logic       yellow
`ifdef TLF_STATE_OUT_EN
  ,
  output logic [1:0] state_o
`endif
);

  localparam int CNT_W = $clog2(max3(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] RED_LD    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             done;
  logic             load;
  logic [CNT_W-1:0] load_val;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (RED_CYCLES - 1)
  ) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RED;
    end else begin
      state <= state_nxt;
    end
  end

  // Illegal encoding falls to the red decode and restarts a full red phase immediately.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = RED_LD;
    red       = 1'b1;
    green     = 1'b0;
    yellow    = 1'b0;
    case (state)
      RED: begin
        if (done) begin
          state_nxt = GREEN;
          load      = 1'b1;
          load_val  = GREEN_LD;
        end
      end
      GREEN: begin
        red   = 1'b0;
        green = 1'b1;
        if (done) begin
          state_nxt = YELLOW;
          load      = 1'b1;
          load_val  = YELLOW_LD;
        end
      end
      YELLOW: begin
        red    = 1'b0;
        yellow = 1'b1;
        if (done) begin
          state_nxt = RED;
          load      = 1'b1;
          load_val  = RED_LD;
        end
      end
      default: begin
        state_nxt = RED;
        load      = 1'b1;
        load_val  = RED_LD;
      end
    endcase
  end

`ifdef TLF_STATE_OUT_EN
  assign state_o = state;
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomised-reset bench: three parameterisations checked every cycle against an edge-count reference model.
module tb_traffic_light_fsm;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst    = 1'b1;

  logic r0, g0, y0;
  logic r1, g1, y1;
  logic r2, g2, y2;
`ifdef TLF_STATE_OUT_EN
  logic [1:0] s0, s1, s2;
`endif

  int tests = 0;
  int fails = 0;
  int n     = 0;  // rising edges seen since the last reset release

  int tab_n  [8] = '{5, 6, 13, 14, 16, 17, 22, 23};
  int tab_ph [8] = '{0, 1, 1, 2, 2, 0, 0, 1};

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  traffic_light_fsm dut (
    .clk(clk), .rst(rst), .red(r0), .green(g0), .yellow(y0)
`ifdef TLF_STATE_OUT_EN
    , .state_o(s0)
`endif
  );

  traffic_light_fsm #(.RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1)) dut_min (
    .clk(clk), .rst(rst), .red(r1), .green(g1), .yellow(y1)
`ifdef TLF_STATE_OUT_EN
    , .state_o(s1)
`endif
  );

  traffic_light_fsm #(.RED_CYCLES(6), .GREEN_CYCLES(20), .YELLOW_CYCLES(3)) dut_long (
    .clk(clk), .rst(rst), .red(r2), .green(g2), .yellow(y2)
`ifdef TLF_STATE_OUT_EN
    , .state_o(s2)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
    end
  endtask

  // Phase index (0 red, 1 green, 2 yellow) after cyc edges, from position within the period.
  function automatic int exp_phase(input int cyc, input int rc, input int gc, input int yc);
    int p;
    p = cyc % (rc + gc + yc);
    if (p < rc) return 0;
    if (p < rc + gc) return 1;
    return 2;
  endfunction

  task automatic check_lamps(input string tag, input logic r, input logic g, input logic y,
                             input int ph);
    check({tag, "_red"},    int'(r), int'(ph == 0));
    check({tag, "_green"},  int'(g), int'(ph == 1));
    check({tag, "_yellow"}, int'(y), int'(ph == 2));
    check({tag, "_onehot"}, int'(r) + int'(g) + int'(y), 1);
  endtask

  task automatic check_all(input string tag);
    check_lamps({tag, "_def"},  r0, g0, y0, exp_phase(n, 6, 8, 3));
    check_lamps({tag, "_min"},  r1, g1, y1, exp_phase(n, 1, 1, 1));
    check_lamps({tag, "_long"}, r2, g2, y2, exp_phase(n, 6, 20, 3));
`ifdef TLF_STATE_OUT_EN
    check({tag, "_st_def"},  int'(s0), exp_phase(n, 6, 8, 3));
    check({tag, "_st_min"},  int'(s1), exp_phase(n, 1, 1, 1));
    check({tag, "_st_long"}, int'(s2), exp_phase(n, 6, 20, 3));
`endif
  endtask

  task automatic check_table();
    int ph_got;
    for (int i = 0; i < 8; i++) begin
      if (n == tab_n[i]) begin
        ph_got = r0 ? 0 : (g0 ? 1 : (y0 ? 2 : 3));
        check("edge_table", ph_got, tab_ph[i]);
      end
    end
  endtask

  // Reset asserted between edges; lamps must go red without waiting for a clock.
  task automatic do_reset(input int hold);
    #2 rst = 1'b0;
    #1;
    n = 0;
    check_all("async_rst");
    repeat (hold) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) n++;
    @(negedge clk);
    check_all("cyc");
    check_table();
  endtask

  initial begin
    #3 rst = 1'b0;
    #1;
    n = 0;
    check_all("rst_no_clk");

    check("cnt_w_def",  dut.CNT_W,      4);
    check("cnt_w_min",  dut_min.CNT_W,  1);
    check("cnt_w_long", dut_long.CNT_W, 6);

    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 30; i++) step();

    do_reset(1);
    for (int i = 0; i < 10; i++) step();
    check("pre_rst_green", int'(g0), 1);
    do_reset(2);
    for (int i = 0; i < 35; i++) step();

    for (int i = 0; i < 400; i++) begin
      step();
      if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
